adc_frame_align_ctrl: RTL and testbench
=======================================

// Module: adc_frame_align_ctrl
// PURPOSE
//  Frame-alignment sequencer for the ADC LVDS frontend, dco_clk domain.
//  Checks FCO frame markers against deserialized word strobes and issues bitslip pulses to the deserializer until the frame phase is stable.
//  Declares/holds lock through `aligned`, which gates FIFO writes in adc_lvds_frontend_top.
// PARAMETERS
//  PERIOD         16  words per frame (FCO spacing, in word_valid strobes)
//  LOCK_FRAMES     4  consecutive good frames required to assert aligned
//  UNLOCK_FRAMES   3  consecutive bad frames in LOCKED that drop aligned
//  SETTLE_CYC      8  dco_clk cycles inputs are ignored after each bitslip
//  MAX_SLIP       16  slip positions before slip_cnt wraps
// PORTS
//  dco_clk        in   1                     frame/word clock
//  rst_n          in   1                     async active-low reset
//  enable         in   1                     0 forces IDLE
//  realign_req    in   1                     1-cycle pulse: drop lock, restart search
//  word_valid     in   1                     deserializer word strobe
//  fco            in   1                     FCO marker, qualified by word_valid
//  bitslip        out  1                     1-cycle slip pulse to deserializer
//  aligned        out  1                     frame lock
//  lock_lost      out  1                     1-cycle pulse on LOCKED->SEARCH
//  slip_cnt       out  $clog2(MAX_SLIP)      slips since last lock
//  slip_exhausted out  1                     sticky: slip_cnt wrapped without lock
//  state_dbg      out  3                     current align_state_t
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0; async assert, sync release.
//  Frame event: fco&word_valid. wcnt counts word_valid, cleared to 0 by a frame event.
//  good_frame = frame event with wcnt==PERIOD-1.
//  bad_frame = frame event with wcnt!=PERIOD-1, or wcnt reaching 2*PERIOD-1 with no fco (timeout; wcnt clears).
//  The first frame event after entering SEARCH only syncs wcnt; it is neither good nor bad.
//  FSM (all outputs registered, Moore):
//   IDLE:   enable=1 -> SEARCH.
//   SEARCH: good -> VERIFY (good_cnt=1); bad -> SLIP.
//   VERIFY: good -> good_cnt++; good_cnt reaching LOCK_FRAMES -> LOCKED; bad -> SLIP.
//   SLIP:   exactly 1 cycle; bitslip=1; slip_cnt++ (wraps MAX_SLIP-1->0, sets slip_exhausted); -> SETTLE.
//   SETTLE: SETTLE_CYC cycles; word_valid/fco ignored; wcnt held 0; -> SEARCH (unsynced).
//   LOCKED: aligned=1; slip_cnt, slip_exhausted cleared on entry.
//           good clears bad_cnt; bad -> bad_cnt++.
//           bad_cnt reaching UNLOCK_FRAMES -> SEARCH, aligned=0 next cycle, lock_lost pulse.
//  aligned rises on the cycle after the locking frame event; falls with the state change.
//  enable=0 (any state): next cycle IDLE, aligned=0, no lock_lost pulse, counters cleared except slip_exhausted.
//  realign_req (any non-IDLE state): -> SEARCH, unsynced.
//   From LOCKED it also pulses lock_lost.
//   realign_req has priority over a same-cycle frame event; enable=0 has priority over both.
//  Frame event in the same cycle as the timeout: the frame event wins (evaluated normally).
//  Stalls: no word_valid means no counting; FCO spacing is measured in words, not cycles.
// STRUCTURE
//  adc_frontend_pkg: typedef enum logic [2:0] align_state_t {IDLE,SEARCH,VERIFY,SLIP,SETTLE,LOCKED};
//   default-parameter localparams.
//  Sub-module adc_frame_period_checker: wcnt, sync flag, timeout.
//   Outputs good_frame/bad_frame pulses; inputs clr.
//  Top holds the FSM and the good/bad/slip/settle counters.
// TESTING
//  1 FCO every 16 words from enable -> sync on fco#1, good on #2-#5; aligned=1 the cycle after fco#5; no bitslip.
//  2 FCO spacing 15 -> bitslip pulse 1 cycle after the 2nd fco; slip_cnt=1.
//    No reaction for 8 cycles; then lock after re-sync with spacing 16.
//  3 LOCKED, then 3 bad frames -> aligned 0 + lock_lost pulse after the 3rd.
//    2 bad then 1 good -> aligned stays 1.
//  4 No fco for 32 word_valid -> timeout bitslip.
//    Stall word_valid for 50 cycles mid-frame -> no bad frame.
//  5 Never-valid FCO -> 16 slips; slip_cnt wraps to 0, slip_exhausted=1.
//    Later lock clears both.
//  6 rst_n low in LOCKED -> all outputs 0 immediately.
//    enable low -> IDLE next cycle.
//    realign_req with a coincident good fco -> SEARCH, lock_lost=1.

Source files
------------

// File: rtl/adc_frame_align_ctrl_pkg.sv
// Shared types and default parameters for the ADC LVDS frontend frame-alignment logic.
package adc_frontend_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    VERIFY = 3'd2,
    SLIP   = 3'd3,
    SETTLE = 3'd4,
    LOCKED = 3'd5
  } align_state_t;

  localparam int PERIOD_DEF        = 16;
  localparam int LOCK_FRAMES_DEF   = 4;
  localparam int UNLOCK_FRAMES_DEF = 3;
  localparam int SETTLE_CYC_DEF    = 8;
  localparam int MAX_SLIP_DEF      = 16;
  localparam int SLIP_W_DEF        = $clog2(MAX_SLIP_DEF);

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_frame_align_ctrl_if.sv
// Frame/word strobes in, bitslip and lock status out, between the deserializer and the aligner.
interface adc_frame_align_ctrl_if #(
  parameter int SLIP_W = adc_frontend_pkg::SLIP_W_DEF
);
  logic              enable;
  logic              realign_req;
  logic              word_valid;
  logic              fco;
  logic              bitslip;
  logic              aligned;
  logic              lock_lost;
  logic [SLIP_W-1:0] slip_cnt;
  logic              slip_exhausted;
  logic [2:0]        state_dbg;

  modport master (
    output enable, realign_req, word_valid, fco,
    input  bitslip, aligned, lock_lost, slip_cnt, slip_exhausted, state_dbg
  );

  modport slave (
    input  enable, realign_req, word_valid, fco,
    output bitslip, aligned, lock_lost, slip_cnt, slip_exhausted, state_dbg
  );
endinterface

// File: rtl/adc_frame_align_ctrl_period_checker.sv
// Measures FCO spacing in word strobes and flags each frame event as good or bad.
module adc_frame_period_checker
  import adc_frontend_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic dco_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic word_valid,
  input  logic fco,
  output logic good_frame,
  output logic bad_frame
);
  localparam int WCNT_W = cnt_w(2 * PERIOD - 1);

  logic [WCNT_W-1:0] wcnt;
  logic              synced;
  logic              frame_ev;
  logic              at_period;
  logic              at_timeout;

  assign frame_ev   = word_valid & fco;
  assign at_period  = (wcnt == WCNT_W'(PERIOD - 1));
  // The next plain word would take wcnt to 2*PERIOD-1: that word is the timeout.
  assign at_timeout = (wcnt == WCNT_W'(2 * PERIOD - 2));

  assign good_frame = synced & frame_ev & at_period;
  assign bad_frame  = (synced & frame_ev & ~at_period) | (word_valid & ~fco & at_timeout);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= '0;
      synced <= 1'b0;
    end else if (clr) begin
      wcnt   <= '0;
      synced <= 1'b0;
    end else if (frame_ev) begin
      wcnt   <= '0;
      synced <= 1'b1;
    end else if (word_valid) begin
      wcnt <= at_timeout ? '0 : wcnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_frame_align_ctrl.sv
// Frame-alignment sequencer: slips the deserializer until FCO lands every PERIOD words, then holds lock.
module adc_frame_align_ctrl
  import adc_frontend_pkg::*;
#(
  parameter int PERIOD        = PERIOD_DEF,
  parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF,
  parameter int UNLOCK_FRAMES = UNLOCK_FRAMES_DEF,
  parameter int SETTLE_CYC    = SETTLE_CYC_DEF,
  parameter int MAX_SLIP      = MAX_SLIP_DEF
) (
  input logic                   dco_clk,
  input logic                   rst_n,
  adc_frame_align_ctrl_if.slave bus
);
  localparam int SLIP_W   = $clog2(MAX_SLIP);
  localparam int GOOD_W   = cnt_w(LOCK_FRAMES);
  localparam int BAD_W    = cnt_w(UNLOCK_FRAMES);
  localparam int SETTLE_W = cnt_w(SETTLE_CYC);

  align_state_t        state;
  logic [GOOD_W-1:0]   good_cnt;
  logic [BAD_W-1:0]    bad_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SLIP_W-1:0]   slip_cnt;
  logic                bitslip;
  logic                aligned;
  logic                lock_lost;
  logic                slip_exhausted;

  logic good_frame;
  logic bad_frame;
  logic unlock_now;
  logic clr;

  adc_frame_period_checker #(
    .PERIOD(PERIOD)
  ) u_period_checker (
    .dco_clk    (dco_clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .word_valid (bus.word_valid),
    .fco        (bus.fco),
    .good_frame (good_frame),
    .bad_frame  (bad_frame)
  );

  assign unlock_now = (state == LOCKED) && bad_frame && (bad_cnt == BAD_W'(UNLOCK_FRAMES - 1));

  // Any path that (re)enters SEARCH, or a state that ignores the inputs, leaves the checker unsynced.
  // NOTE: the default comes first so no path through the block can infer a latch.
  always_comb begin
    clr = 1'b1;
    if (bus.enable && (state inside {SEARCH, VERIFY, LOCKED}) && !bus.realign_req && !unlock_now)
      clr = 1'b0;
  end

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      good_cnt       <= '0;
      bad_cnt        <= '0;
      settle_cnt     <= '0;
      slip_cnt       <= '0;
      bitslip        <= 1'b0;
      aligned        <= 1'b0;
      lock_lost      <= 1'b0;
      slip_exhausted <= 1'b0;
    end else begin
      bitslip   <= 1'b0;
      lock_lost <= 1'b0;
      if (!bus.enable) begin
        state      <= IDLE;
        aligned    <= 1'b0;
        good_cnt   <= '0;
        bad_cnt    <= '0;
        settle_cnt <= '0;
        slip_cnt   <= '0;
      end else if (bus.realign_req && state != IDLE) begin
        state      <= SEARCH;
        aligned    <= 1'b0;
        lock_lost  <= (state == LOCKED);
        good_cnt   <= '0;
        bad_cnt    <= '0;
        settle_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: state <= SEARCH;
          SEARCH, VERIFY: begin
            if (good_frame) begin
              if (state == SEARCH) begin
                state    <= VERIFY;
                good_cnt <= GOOD_W'(1);
              end else if (good_cnt == GOOD_W'(LOCK_FRAMES - 1)) begin
                state          <= LOCKED;
                aligned        <= 1'b1;
                good_cnt       <= '0;
                bad_cnt        <= '0;
                slip_cnt       <= '0;
                slip_exhausted <= 1'b0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else if (bad_frame) begin
              state    <= SLIP;
              bitslip  <= 1'b1;
              good_cnt <= '0;
              if (slip_cnt == SLIP_W'(MAX_SLIP - 1)) begin
                slip_cnt       <= '0;
                slip_exhausted <= 1'b1;
              end else begin
                slip_cnt <= slip_cnt + 1'b1;
              end
            end
          end
          SLIP: begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
              state      <= SEARCH;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (good_frame) begin
              bad_cnt <= '0;
            end else if (bad_frame) begin
              if (unlock_now) begin
                state     <= SEARCH;
                aligned   <= 1'b0;
                lock_lost <= 1'b1;
                bad_cnt   <= '0;
              end else begin
                bad_cnt <= bad_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.bitslip        = bitslip;
  assign bus.aligned        = aligned;
  assign bus.lock_lost      = lock_lost;
  assign bus.slip_cnt       = slip_cnt;
  assign bus.slip_exhausted = slip_exhausted;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Directed bench for adc_frame_align_ctrl: stimulus queues expected output events, a monitor pops and compares.
module tb_adc_frame_align_ctrl;
  import adc_frontend_pkg::*;

  typedef enum logic [1:0] {EV_SLIP, EV_LOCK, EV_UNLOCK, EV_LOST} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       slip;
    logic     exh;
    logic     lost;
  } ev_t;

  logic dco_clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerrors = 0;
  logic prev_aligned = 1'b0;
  ev_t  exp_q[$];

  adc_frame_align_ctrl_if bus ();

  adc_frame_align_ctrl dut (
    .dco_clk (dco_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 dco_clk = ~dco_clk;
  always @(posedge dco_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input int slip, input logic exh, input logic lost);
    ev_t ev;
    ev.kind = k; ev.cyc = c; ev.slip = slip; ev.exh = exh; ev.lost = lost;
    exp_q.push_back(ev);
  endtask

  task automatic post(input ev_kind_t k);
    ev_t exp;
    if (exp_q.size() == 0) begin
      nchecks++;
      nerrors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected no event", k.name(), cyc);
    end else begin
      exp = exp_q.pop_front();
      check({"ev_kind_", exp.kind.name()}, 32'(k), 32'(exp.kind));
      check({"ev_cycle_", exp.kind.name()}, cyc, exp.cyc);
      check({"ev_slip_cnt_", exp.kind.name()}, 32'(bus.slip_cnt), exp.slip);
      check({"ev_slip_exhausted_", exp.kind.name()}, 32'(bus.slip_exhausted), 32'(exp.exh));
      check({"ev_lock_lost_", exp.kind.name()}, 32'(bus.lock_lost), 32'(exp.lost));
    end
  endtask

  // Monitor: every bitslip pulse, aligned edge, or stray lock_lost is an event to be matched.
  always @(negedge dco_clk) begin
    if (bus.bitslip === 1'b1) post(EV_SLIP);
    if (bus.aligned !== prev_aligned) post(bus.aligned ? EV_LOCK : EV_UNLOCK);
    else if (bus.lock_lost === 1'b1) post(EV_LOST);
    prev_aligned = bus.aligned;
  end

  task automatic tick(input logic wv, input logic f, input logic rr, output int e);
    bus.word_valid  = wv;
    bus.fco         = f;
    bus.realign_req = rr;
    @(posedge dco_clk);
    #1;
    e = cyc;
    bus.word_valid  = 1'b0;
    bus.fco         = 1'b0;
    bus.realign_req = 1'b0;
  endtask

  task automatic words(input int n);
    int e;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic settle_with_fco(input int n);
    int e;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, e);
  endtask

  task automatic fco_word(output int e);
    tick(1'b1, 1'b1, 1'b0, e);
  endtask

  // From unsynced SEARCH: sync on the first FCO, then four good frames lock on the fifth FCO.
  task automatic lock_seq();
    int e;
    fco_word(e);
    repeat (4) begin
      words(15);
      fco_word(e);
    end
    push(EV_LOCK, e, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.realign_req = 1'b0;
    bus.word_valid  = 1'b0;
    bus.fco         = 1'b0;
    repeat (3) @(posedge dco_clk);
    #1;
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    check("rst_aligned", 32'(bus.aligned), 0);
    check("rst_bitslip", 32'(bus.bitslip), 0);
    check("rst_lock_lost", 32'(bus.lock_lost), 0);
    check("rst_slip_cnt", 32'(bus.slip_cnt), 0);
    check("rst_slip_exhausted", 32'(bus.slip_exhausted), 0);
    rst_n      = 1'b1;
    bus.enable = 1'b1;

    // Clean FCO every 16 words from enable.
    idle(1);
    check("enable_to_search", 32'(bus.state_dbg), 32'(SEARCH));
    lock_seq();
    check("locked_state", 32'(bus.state_dbg), 32'(LOCKED));

    // Two bad frames then a good one hold lock; three bad frames drop it.
    words(10); fco_word(e);
    words(10); fco_word(e);
    words(15); fco_word(e);
    check("aligned_after_2bad_1good", 32'(bus.aligned), 1);
    repeat (3) begin
      words(10);
      fco_word(e);
    end
    push(EV_UNLOCK, e, 0, 1'b0, 1'b1);
    check("unlock_to_search", 32'(bus.state_dbg), 32'(SEARCH));

    // Spacing 15 forces a slip; FCO during the settle window must be ignored.
    fco_word(e);
    words(14);
    fco_word(e);
    push(EV_SLIP, e, 1, 1'b0, 1'b0);
    settle_with_fco(9);
    check("slip_cnt_after_slip", 32'(bus.slip_cnt), 1);
    check("settle_done_search", 32'(bus.state_dbg), 32'(SEARCH));
    lock_seq();

    // Realign with a coincident good FCO wins over the frame event.
    words(15);
    tick(1'b1, 1'b1, 1'b1, e);
    push(EV_UNLOCK, e, 0, 1'b0, 1'b1);
    check("realign_to_search", 32'(bus.state_dbg), 32'(SEARCH));

    // Missing FCO times out after 31 plain words; a long word_valid stall does not count.
    fco_word(e);
    words(30);
    tick(1'b1, 1'b0, 1'b0, e);
    push(EV_SLIP, e, 1, 1'b0, 1'b0);
    words(9);
    fco_word(e);
    words(8);
    idle(50);
    words(7);
    fco_word(e);
    check("stall_good_to_verify", 32'(bus.state_dbg), 32'(VERIFY));
    repeat (3) begin
      words(15);
      fco_word(e);
    end
    push(EV_LOCK, e, 0, 1'b0, 1'b0);

    // No FCO at all: slip_cnt wraps after 16 slips and sets slip_exhausted; a later lock clears both.
    tick(1'b0, 1'b0, 1'b1, e);
    push(EV_UNLOCK, e, 0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) begin
      words(30);
      tick(1'b1, 1'b0, 1'b0, e);
      push(EV_SLIP, e, (k + 1) % 16, (k >= 15), 1'b0);
      idle(9);
      if (k == 15) begin
        check("wrap_slip_cnt", 32'(bus.slip_cnt), 0);
        check("wrap_slip_exhausted", 32'(bus.slip_exhausted), 1);
      end
    end
    lock_seq();
    check("lock_clears_exhausted", 32'(bus.slip_exhausted), 0);

    // Reset while locked clears outputs without waiting for a clock edge.
    words(3);
    push(EV_UNLOCK, cyc, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_aligned", 32'(bus.aligned), 0);
    check("async_rst_state", 32'(bus.state_dbg), 32'(IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(1);
    lock_seq();

    // Dropping enable returns to IDLE on the next edge with no lock_lost pulse.
    bus.enable = 1'b0;
    tick(1'b1, 1'b1, 1'b0, e);
    push(EV_UNLOCK, e, 0, 1'b0, 1'b0);
    check("disable_to_idle", 32'(bus.state_dbg), 32'(IDLE));
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
